mib_cu_arbiter: RTL and testbench

Round-robin arbiter that shares one move-instruction bus (MIB) control port among `NUM_CU` control units. Each control unit presents a move request (`move_from`/`move_to`) and/or an immediate write (`immediate_addr`/`immediate`). The arbiter grants exactly one control unit at a time, routes that unit's fields onto the single `cu` consumer port of an MIB instance, and returns that MIB's acks to the granted unit only. It sits between the control units and the MIB.

---
 rtl/mib_cu_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mib_cu_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mib_cu_arbiter.sv
// mib_cu_arbiter: round-robin arbiter sharing one MIB control port among NUM_CU control units.
//
// Each control unit presents a move request and/or an immediate write. One unit is granted at a
// time. Its fields are routed onto the MIB cu port, and the MIB acks are returned to that unit
// only. The grant is held until every valid channel of the owner has been acked.
//
// Ports:
//   clock, reset            sole clock; synchronous active-high reset
//   req_move_*              per-unit move request (valid, from, to) and ack pulse
//   req_immediate_*         per-unit immediate request (valid, addr, data) and ack pulse
//   mib_move_*              move channel towards the MIB, ack back from it
//   mib_immediate_*         immediate channel towards the MIB, ack back from it
//   grant                   one-hot current owner, zero when idle
//   busy                    high while a unit is granted
//   grant_count             (only with MIB_ARB_STATS_EN) per-unit saturating 16-bit grant counters
//
// Optional feature macro: MIB_ARB_STATS_EN enables the grant_count port and counters.

module mib_cu_arbiter #(
    parameter int unsigned NUM_CU     = 4,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_CU-1:0]            req_move_valid,
    input  logic [NUM_CU*ADDR_WIDTH-1:0] req_move_from,
    input  logic [NUM_CU*ADDR_WIDTH-1:0] req_move_to,
    output logic [NUM_CU-1:0]            req_move_ack,
    input  logic [NUM_CU-1:0]            req_immediate_valid,
    input  logic [NUM_CU*ADDR_WIDTH-1:0] req_immediate_addr,
    input  logic [NUM_CU*DATA_WIDTH-1:0] req_immediate,
    output logic [NUM_CU-1:0]            req_immediate_ack,
    output logic                         mib_move_valid,
    output logic [ADDR_WIDTH-1:0]        mib_move_from,
    output logic [ADDR_WIDTH-1:0]        mib_move_to,
    input  logic                         mib_move_ack,
    output logic                         mib_immediate_valid,
    output logic [ADDR_WIDTH-1:0]        mib_immediate_addr,
    output logic [DATA_WIDTH-1:0]        mib_immediate,
    input  logic                         mib_immediate_ack,
    output logic [NUM_CU-1:0]            grant,
    output logic                         busy
`ifdef MIB_ARB_STATS_EN
    ,
    output logic [NUM_CU*16-1:0]         grant_count
`endif
);

    localparam int unsigned PtrW = (NUM_CU > 1) ? $clog2(NUM_CU) : 1;

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e            state_q;
    logic [NUM_CU-1:0] grant_q;
    logic [PtrW-1:0]   grant_idx_q;
    logic [PtrW-1:0]   rr_ptr_q;
    logic              busy_q;

    logic [NUM_CU-1:0] req_any;
    logic              found;
    logic [PtrW-1:0]   sel_idx;
    logic              release_now;
    logic [PtrW-1:0]   next_ptr;

    assign req_any = req_move_valid | req_immediate_valid;

    // Round-robin search: first requester at or after rr_ptr_q, wrapping modulo NUM_CU.
    always_comb begin
        logic [PtrW-1:0] idx;
        found   = 1'b0;
        sel_idx = '0;
        idx     = rr_ptr_q;
        for (int unsigned k = 0; k < NUM_CU; k++) begin
            if (!found && req_any[idx]) begin
                found   = 1'b1;
                sel_idx = idx;
            end
            idx = (idx == PtrW'(NUM_CU - 1)) ? '0 : idx + PtrW'(1);
        end
    end

    // Muxes are gated by the registered grant, so nothing reaches the MIB while idle.
    always_comb begin
        mib_move_valid      = 1'b0;
        mib_move_from       = '0;
        mib_move_to         = '0;
        mib_immediate_valid = 1'b0;
        mib_immediate_addr  = '0;
        mib_immediate       = '0;
        for (int unsigned i = 0; i < NUM_CU; i++) begin
            if (grant_q[i]) begin
                mib_move_valid      = req_move_valid[i];
                mib_move_from       = req_move_from[i*ADDR_WIDTH +: ADDR_WIDTH];
                mib_move_to         = req_move_to[i*ADDR_WIDTH +: ADDR_WIDTH];
                mib_immediate_valid = req_immediate_valid[i];
                mib_immediate_addr  = req_immediate_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                mib_immediate       = req_immediate[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Acks pass straight through to the owner only.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CU; i++) begin
            req_move_ack[i]      = grant_q[i] & mib_move_ack & mib_move_valid;
            req_immediate_ack[i] = grant_q[i] & mib_immediate_ack & mib_immediate_valid;
        end
    end

    // Release once no channel stays pending past this cycle; this also covers an owner that
    // drops both valids without an ack.
    assign release_now = !(mib_move_valid && !mib_move_ack) &&
                         !(mib_immediate_valid && !mib_immediate_ack);

    assign next_ptr = (grant_idx_q == PtrW'(NUM_CU - 1)) ? '0 : grant_idx_q + PtrW'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q     <= StGrant;
                        grant_q     <= NUM_CU'(1) << sel_idx;
                        grant_idx_q <= sel_idx;
                        busy_q      <= 1'b1;
                    end
                end
                StGrant: begin
                    if (release_now) begin
                        state_q  <= StIdle;
                        grant_q  <= '0;
                        busy_q   <= 1'b0;
                        rr_ptr_q <= next_ptr;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

`ifdef MIB_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_CU];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CU; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (state_q == StIdle && found && cnt_q[sel_idx] != 16'hFFFF) begin
            cnt_q[sel_idx] <= cnt_q[sel_idx] + 16'd1;
        end
    end

    always_comb begin
        grant_count = '0;
        for (int unsigned i = 0; i < NUM_CU; i++) begin
            grant_count[i*16 +: 16] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_mib_cu_arbiter.sv
module tb_mib_cu_arbiter;

    localparam int unsigned NCU = 4;
    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic [NCU-1:0]    req_move_valid;
    logic [NCU*AW-1:0] req_move_from;
    logic [NCU*AW-1:0] req_move_to;
    logic [NCU-1:0]    req_move_ack;
    logic [NCU-1:0]    req_immediate_valid;
    logic [NCU*AW-1:0] req_immediate_addr;
    logic [NCU*DW-1:0] req_immediate;
    logic [NCU-1:0]    req_immediate_ack;
    logic              mib_move_valid;
    logic [AW-1:0]     mib_move_from;
    logic [AW-1:0]     mib_move_to;
    logic              mib_move_ack;
    logic              mib_immediate_valid;
    logic [AW-1:0]     mib_immediate_addr;
    logic [DW-1:0]     mib_immediate;
    logic              mib_immediate_ack;
    logic [NCU-1:0]    grant;
    logic              busy;
`ifdef MIB_ARB_STATS_EN
    logic [NCU*16-1:0] grant_count;
`endif

    int passed = 0;
    int total  = 0;

    mib_cu_arbiter #(
        .NUM_CU    (NCU),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .req_move_valid     (req_move_valid),
        .req_move_from      (req_move_from),
        .req_move_to        (req_move_to),
        .req_move_ack       (req_move_ack),
        .req_immediate_valid(req_immediate_valid),
        .req_immediate_addr (req_immediate_addr),
        .req_immediate      (req_immediate),
        .req_immediate_ack  (req_immediate_ack),
        .mib_move_valid     (mib_move_valid),
        .mib_move_from      (mib_move_from),
        .mib_move_to        (mib_move_to),
        .mib_move_ack       (mib_move_ack),
        .mib_immediate_valid(mib_immediate_valid),
        .mib_immediate_addr (mib_immediate_addr),
        .mib_immediate      (mib_immediate),
        .mib_immediate_ack  (mib_immediate_ack),
        .grant              (grant),
        .busy               (busy)
`ifdef MIB_ARB_STATS_EN
        ,
        .grant_count        (grant_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Move to just after the next rising edge; inputs driven here apply to the new cycle.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    initial begin
        logic [3:0] rr_exp [5];
        rr_exp = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

        // Reset with every request and ack high.
        reset               = 1'b1;
        req_move_valid      = '1;
        req_immediate_valid = '1;
        req_move_from       = 16'hFFFF;
        req_move_to         = 16'hFFFF;
        req_immediate_addr  = 16'hFFFF;
        req_immediate       = '1;
        mib_move_ack        = 1'b1;
        mib_immediate_ack   = 1'b1;
        step();
        sample();
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_mv_valid", mib_move_valid, 0);
        check("rst_im_valid", mib_immediate_valid, 0);
        check("rst_mv_from", mib_move_from, 0);
        check("rst_im_data", mib_immediate, 0);
        check("rst_mv_ack", req_move_ack, 0);
        check("rst_im_ack", req_immediate_ack, 0);
        step();
        reset             = 1'b0;
        mib_move_ack      = 1'b0;
        mib_immediate_ack = 1'b0;
        sample();
        check("rst2_grant", grant, 0);
        step();
        // All requests dropped without ack: protocol-violation release.
        req_move_valid      = '0;
        req_immediate_valid = '0;
        sample();
        check("first_grant_u0", grant, 4'b0001);
        check("first_busy", busy, 1);
        step();
        sample();
        check("violation_release", grant, 0);
        check("violation_busy", busy, 0);

        // Single move from unit 2 (rr_ptr = 1).
        req_move_valid = 4'b0100;
        req_move_from  = 16'h0300;
        req_move_to    = 16'h0500;
        step();
        sample();
        check("mv_c1_grant", grant, 4'b0100);
        check("mv_c1_valid", mib_move_valid, 1);
        check("mv_c1_from", mib_move_from, 3);
        check("mv_c1_to", mib_move_to, 5);
        check("mv_c1_ack", req_move_ack, 0);
        step();
        mib_move_ack = 1'b1;
        sample();
        check("mv_c2_ack", req_move_ack, 4'b0100);
        check("mv_c2_from", mib_move_from, 3);
        check("mv_c2_grant", grant, 4'b0100);
        step();
        mib_move_ack   = 1'b0;
        req_move_valid = '0;
        sample();
        check("mv_c3_grant", grant, 0);
        check("mv_c3_ack", req_move_ack, 0);
        check("mv_c3_from_gated", mib_move_from, 0);

        // Reset mid-grant: unit 3 wins (rr_ptr = 3).
        req_move_valid = 4'b1000;
        req_move_from  = 16'h9000;
        step();
        sample();
        check("rmg_c1_grant", grant, 4'b1000);
        check("rmg_c1_from", mib_move_from, 9);
        step();
        reset = 1'b1;
        sample();
        check("rmg_c2_grant", grant, 4'b1000);
        step();
        reset          = 1'b0;
        req_move_valid = 4'b0001;
        req_move_from  = 16'h0002;
        sample();
        check("rmg_c3_grant", grant, 0);
        check("rmg_c3_valid", mib_move_valid, 0);
        check("rmg_c3_busy", busy, 0);
        step();
        mib_move_ack = 1'b1;
        sample();
        check("rmg_u0_grant", grant, 4'b0001);
        check("rmg_u0_from", mib_move_from, 2);
        check("rmg_u0_ack", req_move_ack, 4'b0001);
        step();
        mib_move_ack   = 1'b0;
        req_move_valid = '0;
        sample();
        check("rmg_u0_release", grant, 0);

        // Round-robin fairness with all four units requesting continuously.
        reset = 1'b1;
        step();
        reset          = 1'b0;
        req_move_valid = 4'b1111;
        req_move_from  = {4'd4, 4'd3, 4'd2, 4'd1};
        for (int n = 0; n < 5; n++) begin
            step();
            sample();
            check($sformatf("rr%0d_grant", n), grant, 4'b0001 << rr_exp[n]);
            check($sformatf("rr%0d_from", n), mib_move_from, rr_exp[n] + 1);
            step();
            mib_move_ack = 1'b1;
            sample();
            check($sformatf("rr%0d_ack", n), req_move_ack, 4'b0001 << rr_exp[n]);
            step();
            mib_move_ack = 1'b0;
            if (n == 4) req_move_valid = '0;
            sample();
            check($sformatf("rr%0d_idle", n), grant, 0);
        end

        // Split completion on unit 1 (rr_ptr = 1).
        step();
        req_move_valid      = 4'b0010;
        req_immediate_valid = 4'b0010;
        req_move_from       = 16'h0060;
        req_immediate_addr  = 16'h0070;
        req_immediate       = '0;
        req_immediate[127:64] = 64'hDEADBEEF00000001;
        step();
        mib_immediate_ack = 1'b1;
        sample();
        check("sp_c1_grant", grant, 4'b0010);
        check("sp_c1_im_valid", mib_immediate_valid, 1);
        check("sp_c1_im_addr", mib_immediate_addr, 7);
        check("sp_c1_im_data", mib_immediate, 64'hDEADBEEF00000001);
        check("sp_c1_im_ack", req_immediate_ack, 4'b0010);
        check("sp_c1_mv_ack", req_move_ack, 0);
        step();
        mib_immediate_ack   = 1'b0;
        req_immediate_valid = '0;
        sample();
        check("sp_c2_grant", grant, 4'b0010);
        check("sp_c2_im_valid", mib_immediate_valid, 0);
        check("sp_c2_im_ack", req_immediate_ack, 0);
        check("sp_c2_mv_valid", mib_move_valid, 1);
        step();
        mib_move_ack = 1'b1;
        sample();
        check("sp_c3_grant", grant, 4'b0010);
        check("sp_c3_mv_ack", req_move_ack, 4'b0010);
        check("sp_c3_im_valid", mib_immediate_valid, 0);
        step();
        mib_move_ack   = 1'b0;
        req_move_valid = '0;
        sample();
        check("sp_c4_grant", grant, 0);
        check("sp_c4_busy", busy, 0);

`ifdef MIB_ARB_STATS_EN
        // Five grants to unit 1 after a fresh reset.
        reset = 1'b1;
        step();
        reset          = 1'b0;
        req_move_valid = 4'b0010;
        for (int n = 0; n < 5; n++) begin
            step();
            mib_move_ack = 1'b1;
            step();
            mib_move_ack = 1'b0;
        end
        req_move_valid = '0;
        sample();
        check("stats_count", grant_count, {16'd0, 16'd0, 16'd5, 16'd0});
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
